// File: rtl/rc_pulse_gen_if.sv
// Command/status bundle of one RC pulse output channel.
// The master drives the width command; the slave (the generator) drives the pulse and status strobes.
interface rc_pulse_gen_if;
    logic        enable;
    logic [15:0] width_us;
    logic        load;
    logic        pulse;
    logic        frame_start;
    logic        clamped;
    logic        failsafe;

    modport master (
        output enable, width_us, load,
        input  pulse, frame_start, clamped, failsafe
    );

    modport slave (
        input  enable, width_us, load,
        output pulse, frame_start, clamped, failsafe
    );
endinterface

// File: rtl/rc_pulse_gen.sv
// Hobby-RC servo pulse generator with a double-buffered width command.
// Optional no-load failsafe is built in when RC_PULSE_FAILSAFE_EN is defined.
module rc_pulse_gen #(
    parameter int CLK_DIV        = 12,
    parameter int FRAME_US       = 20000,
    parameter int MIN_US         = 1000,
    parameter int MAX_US         = 2000,
    parameter int NEUTRAL_US     = 1500,
    parameter int TIMEOUT_FRAMES = 25
) (
    input  logic          clk_i,
    input  logic          reset_i,
    rc_pulse_gen_if.slave bus
);
    localparam int          PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [15:0] FRAME_MAX = 16'(FRAME_US - 1);
    localparam logic [15:0] MIN_W     = 16'(MIN_US);
    localparam logic [15:0] MAX_W     = 16'(MAX_US);
    localparam logic [15:0] NEUT_W    = 16'(NEUTRAL_US);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [15:0]   us_cnt_q;
    logic [15:0]   active_q;
    logic [15:0]   shadow_q;
    logic          pulse_q;
    logic          frame_start_q;
    logic          clamped_q;

    logic          below_d;
    logic          above_d;
    logic [15:0]   ld_val_d;
    logic [15:0]   new_active_d;
    logic          us_tick_d;

    assign below_d   = bus.width_us < MIN_W;
    assign above_d   = bus.width_us > MAX_W;
    assign us_tick_d = (presc_q == PRESC_MAX);

    always_comb begin
        ld_val_d = bus.width_us;
        if (below_d) begin
            ld_val_d = MIN_W;
        end else if (above_d) begin
            ld_val_d = MAX_W;
        end
    end

`ifdef RC_PULSE_FAILSAFE_EN
    localparam logic [15:0] TMO_W = 16'(TIMEOUT_FRAMES);

    logic        failsafe_q;
    logic [15:0] frame_cnt_q;

    // A load arriving on the wrap cycle wins over both shadow and neutral (write-through).
    always_comb begin
        new_active_d = failsafe_q ? NEUT_W : shadow_q;
        if (bus.load) begin
            new_active_d = ld_val_d;
        end
    end

    assign bus.failsafe = failsafe_q;
`else
    always_comb begin
        new_active_d = shadow_q;
        if (bus.load) begin
            new_active_d = ld_val_d;
        end
    end

    assign bus.failsafe = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            presc_q       <= '0;
            us_cnt_q      <= '0;
            active_q      <= NEUT_W;
            shadow_q      <= NEUT_W;
            pulse_q       <= 1'b0;
            frame_start_q <= 1'b0;
            clamped_q     <= 1'b0;
`ifdef RC_PULSE_FAILSAFE_EN
            failsafe_q    <= 1'b0;
            frame_cnt_q   <= '0;
`endif
        end else begin
            clamped_q     <= bus.load && (below_d || above_d);
            frame_start_q <= 1'b0;
            if (bus.load) begin
                shadow_q <= ld_val_d;
            end

            case (state_q)
                IDLE: begin
                    pulse_q  <= 1'b0;
                    presc_q  <= '0;
                    us_cnt_q <= '0;
                    if (bus.enable) begin
                        state_q       <= RUN;
                        active_q      <= new_active_d;
                        frame_start_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        // Truncates any pulse in flight; the next enable starts a fresh frame.
                        state_q  <= IDLE;
                        pulse_q  <= 1'b0;
                        presc_q  <= '0;
                        us_cnt_q <= '0;
                    end else begin
                        pulse_q <= (us_cnt_q < active_q);
                        if (us_tick_d) begin
                            presc_q <= '0;
                            if (us_cnt_q == FRAME_MAX) begin
                                us_cnt_q      <= '0;
                                active_q      <= new_active_d;
                                frame_start_q <= 1'b1;
                            end else begin
                                us_cnt_q <= us_cnt_q + 16'd1;
                            end
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

`ifdef RC_PULSE_FAILSAFE_EN
            // Failsafe flag takes effect on active at the wrap after it is raised.
            if (bus.load) begin
                frame_cnt_q <= '0;
                failsafe_q  <= 1'b0;
            end else if (state_q == RUN && !bus.enable) begin
                frame_cnt_q <= '0;
            end else if (state_q == RUN && us_tick_d && us_cnt_q == FRAME_MAX) begin
                if (frame_cnt_q < TMO_W) begin
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end
                if (frame_cnt_q + 16'd1 >= TMO_W) begin
                    failsafe_q <= 1'b1;
                end
            end
`endif
        end
    end

    assign bus.pulse       = pulse_q;
    assign bus.frame_start = frame_start_q;
    assign bus.clamped     = clamped_q;
endmodule

// File: tb/tb_rc_pulse_gen.sv
// Directed bench for rc_pulse_gen using scaled-down timing parameters.
// Add +define+RC_PULSE_FAILSAFE_EN to both RTL and bench to cover the failsafe.
module tb_rc_pulse_gen;
    localparam int CLK_DIV    = 3;
    localparam int FRAME_US   = 100;
    localparam int MIN_US     = 20;
    localparam int MAX_US     = 40;
    localparam int NEUTRAL_US = 30;
    localparam int TMO        = 4;
    localparam int FRAME_CYC  = FRAME_US * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    rc_pulse_gen_if rc_if ();

    rc_pulse_gen #(
        .CLK_DIV(CLK_DIV), .FRAME_US(FRAME_US), .MIN_US(MIN_US),
        .MAX_US(MAX_US), .NEUTRAL_US(NEUTRAL_US), .TIMEOUT_FRAMES(TMO)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (rc_if)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] w;
        int          cl;
        int          hi;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_fs(input string name);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!rc_if.frame_start && g < 2 * FRAME_CYC);
        check({name, "_fs_seen"}, int'(rc_if.frame_start), 1);
    endtask

    task automatic wait_rise(input string name);
        int g = 0;
        while (!rc_if.pulse && g < 2 * FRAME_CYC) begin
            @(negedge clk);
            g++;
        end
        check({name, "_rise_seen"}, int'(rc_if.pulse), 1);
    endtask

    // High time in clk cycles of the next (or current) pulse; optional load on its second cycle.
    task automatic measure_hi(input bit do_load, input logic [15:0] w,
                              output int hi, output int clamp_seen);
        int g = 0;
        hi = 0;
        clamp_seen = 0;
        while (!rc_if.pulse && g < 2 * FRAME_CYC) begin
            @(negedge clk);
            g++;
        end
        if (!rc_if.pulse) begin
            hi = -1;
            return;
        end
        hi = 1;
        if (do_load) begin
            rc_if.width_us = w;
            rc_if.load = 1'b1;
            @(negedge clk);
            rc_if.load = 1'b0;
            clamp_seen = int'(rc_if.clamped);
            if (rc_if.pulse) hi++;
        end
        g = 0;
        while (rc_if.pulse && g < 2 * FRAME_CYC) begin
            @(negedge clk);
            g++;
            if (rc_if.pulse) hi++;
        end
    endtask

    initial begin
        int hi;
        int cs;
        int prev_exp;
        int t0;
        int r;

        vecs[0] = '{16'd24,    0, 72};
        vecs[1] = '{16'd5,     1, 60};
        vecs[2] = '{16'd90,    1, 120};
        vecs[3] = '{16'd40,    0, 120};
        vecs[4] = '{16'd20,    0, 60};
        vecs[5] = '{16'd19,    1, 60};
        vecs[6] = '{16'd41,    1, 120};
        vecs[7] = '{16'd0,     1, 60};
        vecs[8] = '{16'hFFFF,  1, 120};
        vecs[9] = '{16'd33,    0, 99};

        rc_if.enable   = 1'b0;
        rc_if.width_us = 16'd0;
        rc_if.load     = 1'b0;

        // Reset state and idle behaviour.
        repeat (3) @(negedge clk);
        check("rst_pulse", int'(rc_if.pulse), 0);
        check("rst_frame_start", int'(rc_if.frame_start), 0);
        check("rst_clamped", int'(rc_if.clamped), 0);
        check("rst_failsafe", int'(rc_if.failsafe), 0);
        rst = 1'b0;
        r = 0;
        repeat (20) begin
            @(negedge clk);
            if (rc_if.pulse || rc_if.frame_start) r++;
        end
        check("idle_quiet", r, 0);

        // Enable: neutral width, rise one cycle after RUN entry, frame period.
        rc_if.enable = 1'b1;
        @(negedge clk);
        check("en_frame_start", int'(rc_if.frame_start), 1);
        check("en_pulse_low", int'(rc_if.pulse), 0);
        t0 = cyc;
        @(negedge clk);
        check("en_first_rise", int'(rc_if.pulse), 1);
        measure_hi(1'b0, 16'd0, hi, cs);
        check("neutral_hi", hi, NEUTRAL_US * CLK_DIV);
        wait_fs("period");
        check("period_cycles", cyc - t0, FRAME_CYC);
        $display("enable: neutral hi=%0d period=%0d", hi, cyc - t0);

        // Mid-pulse loads: current pulse keeps the old width, next pulse uses the clamped new one.
        prev_exp = NEUTRAL_US * CLK_DIV;
        for (int i = 0; i < 10; i++) begin
            measure_hi(1'b1, vecs[i].w, hi, cs);
            check($sformatf("vec%0d_cur_hi", i), hi, prev_exp);
            check($sformatf("vec%0d_clamped", i), cs, vecs[i].cl);
            measure_hi(1'b0, 16'd0, hi, cs);
            check($sformatf("vec%0d_next_hi", i), hi, vecs[i].hi);
            $display("vec %0d: width_us=%0d clamped=%0d next_hi=%0d", i, vecs[i].w, vecs[i].cl, hi);
            prev_exp = vecs[i].hi;
        end
`ifndef RC_PULSE_FAILSAFE_EN
        check("failsafe_tied_low", int'(rc_if.failsafe), 0);
`endif

        // Load on the exact wrap cycle is written through to the starting frame.
        wait_fs("wrap_ref");
        repeat (FRAME_CYC - 1) @(negedge clk);
        rc_if.width_us = 16'd36;
        rc_if.load = 1'b1;
        @(negedge clk);
        rc_if.load = 1'b0;
        check("wrap_frame_start", int'(rc_if.frame_start), 1);
        check("wrap_clamped", int'(rc_if.clamped), 0);
        measure_hi(1'b0, 16'd0, hi, cs);
        check("wrap_load_hi", hi, 108);
        $display("wrap load: hi=%0d", hi);

        // Mid-pulse disable truncates; re-enable restarts with a full pulse.
        wait_rise("dis");
        repeat (10) @(negedge clk);
        rc_if.enable = 1'b0;
        @(negedge clk);
        check("dis_pulse_low", int'(rc_if.pulse), 0);
        r = 0;
        repeat (400) begin
            @(negedge clk);
            if (rc_if.pulse || rc_if.frame_start) r++;
        end
        check("dis_quiet", r, 0);
        rc_if.enable = 1'b1;
        @(negedge clk);
        check("reen_frame_start", int'(rc_if.frame_start), 1);
        check("reen_pulse_low", int'(rc_if.pulse), 0);
        @(negedge clk);
        check("reen_rise", int'(rc_if.pulse), 1);
        measure_hi(1'b0, 16'd0, hi, cs);
        check("reen_hi", hi, 108);
        $display("re-enable: hi=%0d", hi);

        // Asynchronous reset mid-pulse, then width back to neutral.
        wait_rise("arst");
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pulse", int'(rc_if.pulse), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_frame_start", int'(rc_if.frame_start), 1);
        measure_hi(1'b0, 16'd0, hi, cs);
        check("arst_neutral_hi", hi, NEUTRAL_US * CLK_DIV);
        $display("async reset: hi after restart=%0d", hi);

`ifdef RC_PULSE_FAILSAFE_EN
        // Load MAX, then no loads: failsafe after TMO wraps, neutral from the following frame.
        rc_if.width_us = 16'd40;
        rc_if.load = 1'b1;
        @(negedge clk);
        rc_if.load = 1'b0;
        for (int i = 1; i <= TMO + 1; i++) begin
            wait_fs($sformatf("fs%0d", i));
            check($sformatf("fs%0d_flag", i), int'(rc_if.failsafe), (i >= TMO) ? 1 : 0);
            measure_hi(1'b0, 16'd0, hi, cs);
            check($sformatf("fs%0d_hi", i), hi, (i <= TMO) ? 120 : NEUTRAL_US * CLK_DIV);
            $display("failsafe frame %0d: flag=%0d hi=%0d", i, rc_if.failsafe, hi);
        end
        rc_if.width_us = 16'd22;
        rc_if.load = 1'b1;
        @(negedge clk);
        rc_if.load = 1'b0;
        check("fs_clear", int'(rc_if.failsafe), 0);
        wait_fs("fs_after");
        measure_hi(1'b0, 16'd0, hi, cs);
        check("fs_after_hi", hi, 66);
        $display("failsafe cleared: hi=%0d", hi);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
